// File: rtl/calib_mem_pkg.sv
// Shared types and helpers for the banked calibration store.
//   calib_state_e : background-operation FSM states
//   page_aw/word_aw : address widths for page and word selects
//   ZERO_PAGE     : all-zero constant, sliced to the page width by users
package calib_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    COPY_RD = 2'd2,
    COPY_WR = 2'd3
  } calib_state_e;

  function automatic int page_aw(input int num_pages);
    return (num_pages > 1) ? $clog2(num_pages) : 1;
  endfunction

  function automatic int word_aw(input int words_per_page);
    return (words_per_page > 1) ? $clog2(words_per_page) : 1;
  endfunction

  // Wide enough for 16 words of up to 1024 bits each.
  localparam int MAX_PAGE_W = 16 * 1024;
  localparam logic [MAX_PAGE_W-1:0] ZERO_PAGE = '0;

endpackage

// File: rtl/calib_mem_array.sv
// Flop storage for the calibration store.
//   clk, rst_n : clock, async active-low reset (storage cleared to 0)
//   wr_en, wr_page, wr_data, wr_be : one page-wide write port with a
//                                    per-byte mask across the whole page
//   rd_page, rd_data : combinational page read port
module calib_mem_array import calib_mem_pkg::*; #(
  parameter int NUM_PAGES      = 6,
  parameter int WORDS_PER_PAGE = 9,
  parameter int WORD_W         = 32,
  parameter int PAW            = page_aw(NUM_PAGES)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [PAW-1:0]                   wr_page,
  input  logic [WORDS_PER_PAGE*WORD_W-1:0] wr_data,
  input  logic [WORDS_PER_PAGE*WORD_W/8-1:0] wr_be,
  input  logic [PAW-1:0]                   rd_page,
  output logic [WORDS_PER_PAGE*WORD_W-1:0] rd_data
);
  localparam int PW = WORDS_PER_PAGE * WORD_W;
  localparam int BW = PW / 8;

  logic [NUM_PAGES-1:0][PW-1:0] mem;

  for (genvar p = 0; p < NUM_PAGES; p++) begin : g_page
    for (genvar b = 0; b < BW; b++) begin : g_byte
      logic [7:0] q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          q <= '0;
        else if (wr_en && wr_be[b] && (wr_page == PAW'(p)))
          q <= wr_data[8*b +: 8];
      end
      assign mem[p][8*b +: 8] = q;
    end
  end

  // Out-of-range page selects read as zero.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_PAGES; p++)
      if (rd_page == PAW'(p)) rd_data = mem[p];
  end

endmodule

// File: rtl/calib_mem_banked.sv
// Parametrised calibration-data store with page/word writes, per-byte
// word enables, registered reads, and background bulk clear / page copy.
//   clk, rst_n        : clock, async active-low reset
//   page_we, dword_we : page-wide / byte-masked word writes (page wins)
//   dword_be          : byte enables for dword_we
//   page_addr         : host page select, also copy destination
//   dword_addr        : word select
//   dword_din, page_din : write data (word i of page at [WORD_W*i +: WORD_W])
//   rd_req            : read request, data + rd_valid one cycle later
//   dword_dout, page_dout, rd_valid : registered read results
//   clr_req, copy_req, copy_src : background clear / copy start
//   busy              : background operation in progress
//   addr_err          : one-cycle strobe for any dropped access
module calib_mem_banked import calib_mem_pkg::*; #(
  parameter int NUM_PAGES      = 6,
  parameter int WORDS_PER_PAGE = 9,
  parameter int WORD_W         = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  page_we,
  input  logic                                  dword_we,
  input  logic [WORD_W/8-1:0]                   dword_be,
  input  logic [page_aw(NUM_PAGES)-1:0]         page_addr,
  input  logic [word_aw(WORDS_PER_PAGE)-1:0]    dword_addr,
  input  logic [WORD_W-1:0]                     dword_din,
  input  logic [WORDS_PER_PAGE*WORD_W-1:0]      page_din,
  input  logic                                  rd_req,
  output logic [WORD_W-1:0]                     dword_dout,
  output logic [WORDS_PER_PAGE*WORD_W-1:0]      page_dout,
  output logic                                  rd_valid,
  input  logic                                  clr_req,
  input  logic                                  copy_req,
  input  logic [page_aw(NUM_PAGES)-1:0]         copy_src,
  output logic                                  busy,
  output logic                                  addr_err
);
  localparam int PAW = page_aw(NUM_PAGES);
  localparam int WAW = word_aw(WORDS_PER_PAGE);
  localparam int BPW = WORD_W / 8;
  localparam int PW  = WORDS_PER_PAGE * WORD_W;
  localparam int BW  = WORDS_PER_PAGE * BPW;
  localparam logic [PAW:0] NP_LIM = (PAW+1)'(NUM_PAGES);
  localparam logic [WAW:0] WP_LIM = (WAW+1)'(WORDS_PER_PAGE);

  calib_state_e   state_q;
  logic [PAW-1:0] clr_idx_q, src_q, dst_q;
  logic [PW-1:0]  copy_buf;

  logic           idle, page_ok, word_ok, src_ok, rd_ok;
  logic [WAW-1:0] w_sel;
  logic [PAW-1:0] arr_rd_page;
  logic [PW-1:0]  arr_rd;
  logic [WORD_W-1:0] rd_word;
  logic           wr_en;
  logic [PAW-1:0] wr_page;
  logic [PW-1:0]  wr_data;
  logic [BW-1:0]  wr_be, be_word;
  logic           err_d;

  assign idle    = (state_q == IDLE);
  assign busy    = !idle;
  assign page_ok = {1'b0, page_addr}  < NP_LIM;
  assign src_ok  = {1'b0, copy_src}   < NP_LIM;
  assign word_ok = {1'b0, dword_addr} < WP_LIM;
  assign rd_ok   = page_ok && word_ok;
  // Keep part-selects in range even when the request will be dropped.
  assign w_sel   = word_ok ? dword_addr : '0;

  // The read port is shared: copy source while copying, host otherwise.
  assign arr_rd_page = (state_q == COPY_RD) ? src_q : (page_ok ? page_addr : '0);
  assign rd_word     = arr_rd[WORD_W*w_sel +: WORD_W];

  always_comb begin
    be_word = '0;
    be_word[BPW*w_sel +: BPW] = dword_be;
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_page = page_addr;
    wr_data = page_din;
    wr_be   = '0;
    unique case (state_q)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_page = clr_idx_q;
        wr_data = ZERO_PAGE[PW-1:0];
        wr_be   = '1;
      end
      COPY_WR: begin
        wr_en   = 1'b1;
        wr_page = dst_q;
        wr_data = copy_buf;
        wr_be   = '1;
      end
      IDLE: begin
        if (page_we) begin
          wr_en = page_ok;
          wr_be = '1;
        end else if (dword_we) begin
          wr_en   = rd_ok;
          wr_data = {WORDS_PER_PAGE{dword_din}};
          wr_be   = be_word;
        end
      end
      default: ;
    endcase
  end

  // Dropped accesses: anything while busy, or any out-of-range op in IDLE.
  // A dword_we shadowed by page_we is ignored silently.
  always_comb begin
    if (!idle)
      err_d = page_we | dword_we | rd_req | clr_req | copy_req;
    else
      err_d = (page_we && !page_ok)
           || (!page_we && dword_we && !rd_ok)
           || (rd_req && !rd_ok)
           || (!clr_req && copy_req && !(src_ok && page_ok));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clr_idx_q  <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      copy_buf   <= '0;
      dword_dout <= '0;
      page_dout  <= '0;
      rd_valid   <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      addr_err <= err_d;
      rd_valid <= idle && rd_req;
      // Array read is pre-write, so same-cycle read sees old data.
      if (idle && rd_req) begin
        dword_dout <= rd_ok ? rd_word : '0;
        page_dout  <= rd_ok ? arr_rd  : ZERO_PAGE[PW-1:0];
      end
      unique case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
          end else if (copy_req && src_ok && page_ok) begin
            state_q <= COPY_RD;
            src_q   <= copy_src;
            dst_q   <= page_addr;
          end
        end
        CLEAR: begin
          if (clr_idx_q == PAW'(NUM_PAGES-1)) state_q <= IDLE;
          else clr_idx_q <= clr_idx_q + PAW'(1);
        end
        COPY_RD: begin
          copy_buf <= arr_rd;
          state_q  <= COPY_WR;
        end
        COPY_WR: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  calib_mem_array #(
    .NUM_PAGES(NUM_PAGES), .WORDS_PER_PAGE(WORDS_PER_PAGE),
    .WORD_W(WORD_W), .PAW(PAW)
  ) u_array (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_page(wr_page), .wr_data(wr_data), .wr_be(wr_be),
    .rd_page(arr_rd_page), .rd_data(arr_rd)
  );

endmodule

// File: tb/tb_calib_mem_banked.sv
module tb_calib_mem_banked;
  localparam int NP  = 6;
  localparam int WPP = 9;
  localparam int WW  = 32;
  localparam int PW  = WPP * WW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          page_we, dword_we, rd_req, clr_req, copy_req;
  logic [3:0]    dword_be;
  logic [2:0]    page_addr, copy_src;
  logic [3:0]    dword_addr;
  logic [WW-1:0] dword_din, dword_dout;
  logic [PW-1:0] page_din, page_dout;
  logic          rd_valid, busy, addr_err;

  calib_mem_banked #(.NUM_PAGES(NP), .WORDS_PER_PAGE(WPP), .WORD_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .page_we(page_we), .dword_we(dword_we),
    .dword_be(dword_be), .page_addr(page_addr), .dword_addr(dword_addr),
    .dword_din(dword_din), .page_din(page_din), .rd_req(rd_req),
    .dword_dout(dword_dout), .page_dout(page_dout), .rd_valid(rd_valid),
    .clr_req(clr_req), .copy_req(copy_req), .copy_src(copy_src),
    .busy(busy), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: plain word array plus last returned read data.
  logic [WW-1:0] model [NP][WPP];
  logic [WW-1:0] last_w;
  logic [PW-1:0] last_p;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] mpage(input int p);
    logic [PW-1:0] r;
    for (int i = 0; i < WPP; i++) r[WW*i +: WW] = model[p][i];
    return r;
  endfunction

  function automatic logic [PW-1:0] rand_page();
    logic [PW-1:0] r;
    for (int i = 0; i < WPP; i++) r[WW*i +: WW] = $urandom;
    return r;
  endfunction

  task automatic model_zero();
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < WPP; i++) model[p][i] = '0;
  endtask

  task automatic idle_inputs();
    page_we = 0; dword_we = 0; rd_req = 0; clr_req = 0; copy_req = 0;
    dword_be = '0; page_addr = '0; copy_src = '0; dword_addr = '0;
    dword_din = '0; page_din = '0;
  endtask

  // One host cycle in IDLE: any mix of page write, word write, read.
  task automatic host_step(input bit pw, input bit dw, input bit rd, input int pa, input int wa,
                           input logic [3:0] be, input logic [WW-1:0] dd,
                           input logic [PW-1:0] pd, input string tag);
    bit pok, wok, err;
    pok = (pa < NP);
    wok = (wa < WPP);
    err = 0;
    page_we = pw; dword_we = dw; rd_req = rd; dword_be = be;
    page_addr = 3'(pa); dword_addr = 4'(wa); dword_din = dd; page_din = pd;
    if (rd) begin
      if (pok && wok) begin
        last_w = model[pa][wa];
        last_p = mpage(pa);
      end else begin
        last_w = '0; last_p = '0; err = 1;
      end
    end
    if (pw) begin
      if (pok) for (int i = 0; i < WPP; i++) model[pa][i] = pd[WW*i +: WW];
      else err = 1;
    end else if (dw) begin
      if (pok && wok) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model[pa][wa][8*b +: 8] = dd[8*b +: 8];
      end else err = 1;
    end
    tick();
    idle_inputs();
    chk({tag, ".addr_err"}, addr_err, err);
    chk({tag, ".rd_valid"}, rd_valid, rd);
    chk({tag, ".dword_dout"}, dword_dout, last_w);
    chk({tag, ".page_dout"}, page_dout, last_p);
  endtask

  task automatic read_all(input string tag);
    for (int p = 0; p < NP; p++)
      host_step(0, 0, 1, p, p, 4'h0, '0, '0, tag);
  endtask

  task automatic fill_all();
    for (int p = 0; p < NP; p++)
      host_step(1, 0, 0, p, 0, 4'h0, '0, rand_page(), "fill");
  endtask

  task automatic do_copy(input int src, input int dst, input bit ok, input string tag);
    copy_req = 1; copy_src = 3'(src); page_addr = 3'(dst);
    tick();
    idle_inputs();
    chk({tag, ".busy1"}, busy, ok);
    chk({tag, ".err"}, addr_err, !ok);
    if (ok) begin
      for (int i = 0; i < WPP; i++) model[dst][i] = model[src][i];
      tick();
      chk({tag, ".busy2"}, busy, 1'b1);
      tick();
      chk({tag, ".busy_done"}, busy, 1'b0);
    end
  endtask

  // Starts a clear (optionally with copy_req too) and counts busy cycles;
  // a dword_we is driven on the first busy cycle and must be dropped.
  task automatic do_clear(input bit with_copy, input string tag);
    int n;
    clr_req = 1; copy_req = with_copy; copy_src = 3'd0; page_addr = 3'd1;
    tick();
    idle_inputs();
    n = 0;
    for (int c = 0; c < 20 && busy; c++) begin
      dword_we = (c == 0); dword_be = 4'hF; dword_din = 32'hDEADBEEF;
      tick();
      idle_inputs();
      n++;
      if (c == 0) chk({tag, ".drop_err"}, addr_err, 1'b1);
    end
    chk({tag, ".busy_cycles"}, 32'(n), 32'(NP));
    model_zero();
    read_all({tag, ".rd0"});
  endtask

  initial begin
    logic [PW-1:0] pat;
    idle_inputs();
    model_zero();
    last_w = '0; last_p = '0;
    rst_n = 0;
    tick(); tick();
    chk("rst.busy", busy, 1'b0);
    chk("rst.addr_err", addr_err, 1'b0);
    chk("rst.rd_valid", rd_valid, 1'b0);
    chk("rst.dword_dout", dword_dout, '0);
    chk("rst.page_dout", page_dout, '0);
    rst_n = 1;
    tick();

    host_step(0, 0, 1, 0, 0, 4'h0, '0, '0, "rd_p0w0");
    tick();
    chk("rd_valid_strobe", rd_valid, 1'b0);

    host_step(0, 1, 0, 2, 3, 4'b0101, 32'hA5A5A5A5, '0, "be_wr");
    host_step(0, 0, 1, 2, 3, 4'h0, '0, '0, "be_rd");
    chk("be_value", dword_dout, 32'h00A500A5);

    pat = rand_page();
    host_step(1, 1, 0, 4, 2, 4'hF, 32'h12345678, pat, "prio_wr");
    host_step(0, 0, 1, 4, 2, 4'h0, '0, '0, "prio_rd");
    chk("prio_value", dword_dout, pat[WW*2 +: WW]);

    // Read and write same location same cycle: old data returned.
    host_step(0, 1, 1, 4, 2, 4'hF, 32'hCAFEF00D, '0, "rw_same");
    host_step(0, 0, 1, 4, 2, 4'h0, '0, '0, "rw_after");

    // Out-of-range page and word accesses.
    host_step(1, 0, 0, 7, 0, 4'h0, '0, rand_page(), "oor_pw");
    host_step(0, 1, 0, 2, 12, 4'hF, 32'h1, '0, "oor_dw");
    host_step(0, 0, 1, 7, 0, 4'h0, '0, '0, "oor_rd");
    chk("oor_rd_valid", rd_valid, 1'b1);
    read_all("oor_unchanged");

    for (int it = 0; it < 60; it++) begin
      int pa, wa;
      pa = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
      wa = ($urandom_range(0, 7) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
      host_step($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                pa, wa, 4'($urandom), $urandom, rand_page(), "rand");
    end

    pat = rand_page();
    host_step(1, 0, 0, 5, 0, 4'h0, '0, pat, "copy_fill");
    do_copy(5, 1, 1, "copy51");
    host_step(0, 0, 1, 1, 4, 4'h0, '0, '0, "copy_dst");
    chk("copy_dst_pattern", page_dout, pat);
    host_step(0, 0, 1, 5, 4, 4'h0, '0, '0, "copy_src");
    do_copy(3, 3, 1, "copy_self");
    host_step(0, 0, 1, 3, 0, 4'h0, '0, '0, "copy_self_rd");
    do_copy(6, 0, 0, "copy_bad_src");
    do_copy(0, 7, 0, "copy_bad_dst");
    read_all("copy_bad_unchanged");

    fill_all();
    do_clear(0, "clr");

    // Reset during the second clear cycle aborts it.
    fill_all();
    clr_req = 1;
    tick();
    idle_inputs();
    tick();
    chk("rstclr.busy_pre", busy, 1'b1);
    rst_n = 0;
    #1;
    chk("rstclr.busy", busy, 1'b0);
    tick();
    rst_n = 1;
    model_zero();
    last_w = '0; last_p = '0;
    tick();
    chk("rstclr.busy_after", busy, 1'b0);
    read_all("rstclr.rd0");

    fill_all();
    do_clear(1, "clr_copy");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calib_mem_banked.md
# calib_mem_banked

Parametrised calibration-data store for the PHY calibration path; successor of the fixed 6-page x 9-dword store. Holds NUM_PAGES pages of WORDS_PER_PAGE words and supports page-wide and word-wide writes, per-byte word enables, registered reads with a valid strobe, and two background operations: bulk clear and page-to-page copy. Sits between the calibration sequencer (page traffic) and the host register interface (word traffic).

## Interface
- NUM_PAGES, 6, number of pages (2..16)
- WORDS_PER_PAGE, 9, words per page (2..16)
- WORD_W, 32, word width in bits, multiple of 8
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- page_we  in  1  write page_din to page page_addr
- dword_we  in  1  write dword_din to word dword_addr of page page_addr, gated by dword_be
- dword_be  in  WORD_W/8  byte enables for dword_we
- page_addr  in  $clog2(NUM_PAGES)  page select (host ops; copy destination)
- dword_addr  in  $clog2(WORDS_PER_PAGE)  word select
- dword_din  in  WORD_W  word write data
- page_din  in  WORDS_PER_PAGE*WORD_W  page write data, word i at [WORD_W*i +: WORD_W]
- rd_req  in  1  read page page_addr and word dword_addr
- dword_dout  out  WORD_W  registered word read data
- page_dout  out  WORDS_PER_PAGE*WORD_W  registered page read data
- rd_valid  out  1  one-cycle strobe, read data updated
- clr_req  in  1  start bulk clear of all pages
- copy_req  in  1  start copy of page copy_src into page page_addr
- copy_src  in  $clog2(NUM_PAGES)  copy source page
- busy  out  1  background operation in progress
- addr_err  out  1  one-cycle strobe, dropped access

## Operation
- Reset (rst_n low): storage cleared to 0; dword_dout, page_dout, rd_valid, busy, addr_err = 0; FSM to IDLE. Reset mid-clear or mid-copy aborts it, storage still all-zero.
- FSM states: IDLE, CLEAR, COPY_RD, COPY_WR.
- IDLE: clr_req -> CLEAR with clear index 0; else copy_req -> COPY_RD, latching copy_src and page_addr (dest). clr_req wins over copy_req. Host writes/reads in the same cycle as a request are still serviced.
- CLEAR: zeroes page index per cycle, index increments; after page NUM_PAGES-1 -> IDLE.
- COPY_RD: registers source page into copy buffer -> COPY_WR. COPY_WR: writes buffer to dest page -> IDLE. src == dest is legal, contents unchanged.
- While busy: page_we, dword_we, rd_req, clr_req, copy_req are dropped; any asserted drops pulse addr_err next cycle.
- Write priority: page_we over dword_we (dword_we ignored, no error). dword_we writes only bytes with dword_be set; be = 0 writes nothing.
- Range check: page_addr >= NUM_PAGES, dword_addr >= WORDS_PER_PAGE (word ops), copy_src or dest >= NUM_PAGES -> operation dropped, addr_err pulses; a failing read returns zero data with rd_valid high.
- Read and write to same location same cycle: read returns pre-write data.
- Outputs hold last read data until the next rd_valid.

## Timing
- Writes commit at the rising edge sampling the enable.
- Read: rd_req at cycle N -> dword_dout/page_dout/rd_valid at N+1.
- Clear: clr_req at N -> busy high N+1..N+NUM_PAGES; new host ops accepted at N+NUM_PAGES+1.
- Copy: copy_req at N -> busy high N+1..N+2; dest page valid for reads requested at N+3.
- addr_err: one cycle after the offending input cycle.

## Structure
- Package calib_mem_pkg: state enum calib_state_e, width helper functions for page/word address width, zero-page constant.
- Sub-module calib_mem_array: flop storage with per-page, per-word, per-byte write enables and combinational page read port; the top owns the FSM, range checks, muxing and output registers.

## Test plan
- Reset then rd_req page 0 word 0 -> rd_valid at N+1, dword_dout = 0, page_dout = 0.
- dword_we page 2 word 3 data 0xA5A5A5A5 be 4'b0101, then read -> 0x00A500A5; page_we + dword_we same cycle -> page_din wins.
- page_we page 5 with pattern, copy_req src 5 to page_addr 1 -> busy 2 cycles, read page 1 equals pattern, page 5 unchanged.
- Fill all pages, clr_req -> busy exactly NUM_PAGES cycles, dword_we during busy dropped with addr_err, all pages read 0 afterwards.
- page_addr = 7 write (NUM_PAGES = 6) -> addr_err pulse, storage unchanged; read page 7 -> zero data, rd_valid high.
- Assert rst_n low during CLEAR cycle 2 -> busy 0, FSM IDLE, all reads 0; clr_req and copy_req together -> clear runs.
